// File: rtl/vend_pkg.sv
// vend_pkg: shared coin and state types, coin denominations and the coin value lookup.
//   coin_e     : NICKEL(5) DIME(10) QUARTER(25) DOLLAR(100)
//   state_e    : IDLE COLLECT VEND CHANGE
//   coin_value : coin_e -> value in cents (8 bits)
package vend_pkg;
  typedef enum logic [1:0] {NICKEL, DIME, QUARTER, DOLLAR} coin_e;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;
  localparam logic [7:0] NICKEL_C  = 8'd5;
  localparam logic [7:0] DIME_C    = 8'd10;
  localparam logic [7:0] QUARTER_C = 8'd25;
  localparam logic [7:0] DOLLAR_C  = 8'd100;
  function automatic logic [7:0] coin_value(coin_e c);
    return c == DOLLAR ? DOLLAR_C : c == QUARTER ? QUARTER_C : c == DIME ? DIME_C : NICKEL_C;
  endfunction
endpackage

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy change selector, picks the largest coin not exceeding the remaining credit.
//   credit : in  W  remaining credit in cents
//   coin   : out 2  coin_e to hand out next
module vend_change_sel import vend_pkg::*; #(
  parameter int W = 8
) (
  input  logic [W-1:0] credit,
  output coin_e        coin
);
  always_comb
    coin = 32'(credit) >= 32'(DOLLAR_C)  ? DOLLAR  :
           32'(credit) >= 32'(QUARTER_C) ? QUARTER :
           32'(credit) >= 32'(DIME_C)    ? DIME    : NICKEL;
endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin-accumulating vending FSM with one-cycle vend pulse and coin-by-coin change return.
//   clk, reset_n       : clock, asynchronous active-low reset
//   coin_valid/type    : incoming coin, taken only while coin_accept is high
//   cancel             : refund the credit held in COLLECT
//   coin_accept        : high in IDLE/COLLECT
//   coin_reject        : one-cycle pulse after a coin offered while coin_accept was low
//   vend               : one-cycle sale pulse
//   change_valid/type  : change coin offer, handshaked with change_ready
//   credit             : current credit in cents
module vend_controller import vend_pkg::*; #(
  parameter int PRICE    = 100,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  coin_e               coin_type,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend,
  output logic                change_valid,
  output coin_e               change_type,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit
);
  if (PRICE % 5 != 0 || PRICE < 5 || PRICE > 255) begin : g_price_chk
    $error("vend_controller: PRICE must be a multiple of 5 in 5..255");
  end
  if (PRICE + 95 >= 2 ** CREDIT_W) begin : g_width_chk
    $error("vend_controller: CREDIT_W too narrow for PRICE-5+100");
  end
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, sum, paid;
  logic                vend_q, vend_d, change_valid_q, change_valid_d;
  logic                coin_accept_q, coin_accept_d, coin_reject_q, coin_reject_d;
  coin_e               change_type_q, change_type_d, sel_coin;
  vend_change_sel #(.W(CREDIT_W)) u_sel (.credit(credit_d), .coin(sel_coin));
  // The coin is added before cancel is considered, so a sale reached this cycle beats the refund.
  always_comb begin
    sum = credit_q + (coin_valid && coin_accept_q ? CREDIT_W'(coin_value(coin_type)) : '0);
    paid = credit_q - CREDIT_W'(coin_value(change_type_q));
    state_d = state_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        credit_d = sum >= PRICE_C ? sum - PRICE_C : sum;
        state_d = sum >= PRICE_C ? VEND : cancel && state_q == COLLECT ? CHANGE : sum != '0 ? COLLECT : IDLE;
      end
      VEND: state_d = credit_q != '0 ? CHANGE : IDLE;
      CHANGE: if (change_valid_q && change_ready) begin
        credit_d = paid;
        state_d = paid != '0 ? CHANGE : IDLE;
      end
    endcase
    vend_d = state_d == VEND;
    change_valid_d = state_d == CHANGE;
    change_type_d = state_d == CHANGE ? sel_coin : NICKEL;
    coin_accept_d = state_d == IDLE || state_d == COLLECT;
    coin_reject_d = coin_valid && !coin_accept_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      credit_q <= '0;
      vend_q <= 1'b0;
      change_valid_q <= 1'b0;
      change_type_q <= NICKEL;
      coin_accept_q <= 1'b1;
      coin_reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      vend_q <= vend_d;
      change_valid_q <= change_valid_d;
      change_type_q <= change_type_d;
      coin_accept_q <= coin_accept_d;
      coin_reject_q <= coin_reject_d;
    end
  assign coin_accept = coin_accept_q;
  assign coin_reject = coin_reject_q;
  assign vend = vend_q;
  assign change_valid = change_valid_q;
  assign change_type = change_type_q;
  assign credit = credit_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: two controllers (PRICE 100 and 65) on shared stimulus, checked against a credit-level model.
module tb_vend_controller;
  import vend_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic coin_valid = 1'b0;
  coin_e coin_type = NICKEL;
  logic cancel = 1'b0;
  logic change_ready = 1'b0;
  logic [7:0] credit_o [2];
  logic vend_o [2];
  logic cval_o [2];
  logic acc_o [2];
  logic rej_o [2];
  coin_e ctype_o [2];
  int tests = 0;
  int fails = 0;
  int vals [4] = '{5, 10, 25, 100};
  int price [2] = '{100, 65};
  // Model: credit in cents plus phase (0 taking coins, 1 selling, 2 paying out).
  int cr [2];
  int md [2];
  int rej [2];
  always #5 clk = ~clk;
  vend_controller #(.PRICE(100), .CREDIT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
    .coin_accept(acc_o[0]), .coin_reject(rej_o[0]), .vend(vend_o[0]), .change_valid(cval_o[0]),
    .change_type(ctype_o[0]), .change_ready(change_ready), .credit(credit_o[0]));
  vend_controller #(.PRICE(65), .CREDIT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
    .coin_accept(acc_o[1]), .coin_reject(rej_o[1]), .vend(vend_o[1]), .change_valid(cval_o[1]),
    .change_type(ctype_o[1]), .change_ready(change_ready), .credit(credit_o[1]));
  function automatic int biggest(input int r);
    for (int i = 3; i >= 0; i--) if (vals[i] <= r) return i;
    return 0;
  endfunction
  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask
  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk("credit", k, 32'(credit_o[k]), cr[k]);
      chk("vend", k, 32'(vend_o[k]), 32'(md[k] == 1));
      chk("change_valid", k, 32'(cval_o[k]), 32'(md[k] == 2));
      chk("coin_accept", k, 32'(acc_o[k]), 32'(md[k] == 0));
      chk("coin_reject", k, 32'(rej_o[k]), rej[k]);
      if (md[k] == 2) chk("change_type", k, 32'(ctype_o[k]), biggest(cr[k]));
    end
  endtask
  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_credit", k, 32'(credit_o[k]), 0);
      chk("rst_vend", k, 32'(vend_o[k]), 0);
      chk("rst_change_valid", k, 32'(cval_o[k]), 0);
      chk("rst_change_type", k, 32'(ctype_o[k]), 0);
      chk("rst_coin_reject", k, 32'(rej_o[k]), 0);
      chk("rst_coin_accept", k, 32'(acc_o[k]), 1);
      cr[k] = 0;
      md[k] = 0;
      rej[k] = 0;
    end
  endtask
  task automatic step(input logic cv, input coin_e ct, input logic cn, input logic rdy);
    int s;
    coin_valid = cv;
    coin_type = ct;
    cancel = cn;
    change_ready = rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rej[k] = int'(cv && md[k] != 0);
      if (md[k] == 0) begin
        s = cr[k] + (cv ? vals[ct] : 0);
        if (s >= price[k]) begin
          cr[k] = s - price[k];
          md[k] = 1;
        end else begin
          if (cn && cr[k] > 0) md[k] = 2;
          cr[k] = s;
        end
      end else if (md[k] == 1) md[k] = cr[k] > 0 ? 2 : 0;
      else if (rdy) begin
        cr[k] -= vals[biggest(cr[k])];
        if (cr[k] == 0) md[k] = 0;
      end
    end
    #1;
    check_model();
  endtask
  task automatic idle_steps(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, NICKEL, 1'b0, rdy);
  endtask
  task automatic drain();
    for (int n = 0; n < 40 && (md[0] != 0 || cr[0] != 0 || md[1] != 0 || cr[1] != 0); n++)
      step(1'b0, NICKEL, 1'b1, 1'b1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(1'b1, QUARTER, 1'b0, 1'b1);
    idle_steps(3, 1'b1);
    drain();
    step(1'b1, DOLLAR, 1'b0, 1'b1);
    step(1'b1, NICKEL, 1'b0, 1'b1);
    idle_steps(4, 1'b1);
    drain();
    step(1'b1, DIME, 1'b0, 1'b1);
    step(1'b1, DIME, 1'b0, 1'b1);
    step(1'b0, NICKEL, 1'b1, 1'b1);
    idle_steps(4, 1'b1);
    drain();
    repeat (3) step(1'b1, QUARTER, 1'b0, 1'b1);
    step(1'b1, QUARTER, 1'b1, 1'b1);
    idle_steps(4, 1'b1);
    drain();
    repeat (2) step(1'b1, QUARTER, 1'b0, 1'b1);
    step(1'b1, QUARTER, 1'b1, 1'b1);
    idle_steps(5, 1'b1);
    drain();
    step(1'b1, DOLLAR, 1'b0, 1'b0);
    idle_steps(3, 1'b0);
    step(1'b1, QUARTER, 1'b0, 1'b0);
    idle_steps(2, 1'b0);
    idle_steps(4, 1'b1);
    drain();
    step(1'b1, DOLLAR, 1'b0, 1'b0);
    idle_steps(3, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), coin_e'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
